// File: rtl/pc_seq_pkg.sv
// Shared opcode constants and FSM state encoding for the paper-processor PC sequencer.
package pc_seq_pkg;

    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_NOP = 2'b01;
    localparam logic [1:0] OP_JNO = 2'b10;
    localparam logic [1:0] OP_HLT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_ADV    = 3'd4,
        ST_JUMP   = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    // busy covers every state that belongs to an instruction in flight
    function automatic logic is_active(input state_e s);
        return (s != ST_IDLE) && (s != ST_HALT);
    endfunction

endpackage

// File: rtl/mn_pulse_gen.sv
// Execute-pulse generator: a start loads a down-counter; mn stays high for MN_CYC cycles,
// last_cyc marks the final high cycle so the caller can sample the datapath overflow.
module mn_pulse_gen #(
    parameter int MN_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    output logic mn_o,
    output logic last_cyc_o
);

    localparam int CW = $clog2(MN_CYC + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          mn_q;
    logic          last_q;

    // Next count: load on start, otherwise count down to zero and rest there
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = CW'(MN_CYC);
        end else if (cnt_q != {CW{1'b0}}) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter plus registered pulse/last flags decoded from the next count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= {CW{1'b0}};
            mn_q   <= 1'b0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mn_q   <= (cnt_d != {CW{1'b0}});
            last_q <= (cnt_d == CW'(1));
        end
    end

    assign mn_o       = mn_q;
    assign last_cyc_o = last_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute controller owning the program counter of the paper processor.
// Optional single-step input is enabled by defining PC_SEQ_STEP_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W   = 2,
    parameter int MN_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
`ifdef PC_SEQ_STEP_EN
    input  logic            step,
`endif
    output logic            fetch_req,
    input  logic [1:0]      instr,
    input  logic [PC_W-1:0] tgt,
    input  logic            instr_valid,
    input  logic            ovf,
    output logic [PC_W-1:0] pc,
    output logic            mn,
    output logic            pc_wrap,
    output logic            halted,
    output logic            busy
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [1:0]      instr_q, instr_d;
    logic [PC_W-1:0] tgt_q, tgt_d;
    logic            ovf_flag_q, ovf_flag_d;
    logic            pc_wrap_q, pc_wrap_d;
    logic            fetch_req_q;
    logic            halted_q;
    logic            busy_q;
    logic            mn_start_s;
    logic            mn_last_s;
    logic            mn_s;
    logic            step_go_s;
    logic            single_q;
    logic            cont_s;

`ifdef PC_SEQ_STEP_EN
    logic step_q;
    logic single_d;

    assign step_go_s = step && !step_q && !run;

    // A step launch marks the instruction as single-shot; a run launch clears the mark
    always_comb begin
        single_d = single_q;
        if (state_q == ST_IDLE) begin
            single_d = step_go_s;
        end else begin
            single_d = single_q;
        end
    end

    // Step edge detector and single-shot flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q   <= 1'b0;
            single_q <= 1'b0;
        end else begin
            step_q   <= step;
            single_q <= single_d;
        end
    end
`else
    assign step_go_s = 1'b0;
    assign single_q  = 1'b0;
`endif

    assign cont_s = run && !single_q;

    mn_pulse_gen #(.MN_CYC(MN_CYC)) u_mn (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (mn_start_s),
        .mn_o       (mn_s),
        .last_cyc_o (mn_last_s)
    );

    // Next-state, PC update and operand capture
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        tgt_d      = tgt_q;
        ovf_flag_d = ovf_flag_q;
        pc_wrap_d  = 1'b0;
        mn_start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run || step_go_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (instr_valid) begin
                    instr_d = instr;
                    tgt_d   = tgt;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (instr_q)
                    OP_INC: begin
                        state_d    = ST_EXEC;
                        mn_start_s = 1'b1;
                    end
                    OP_NOP:  state_d = ST_ADV;
                    OP_JNO:  state_d = ST_JUMP;
                    OP_HLT:  state_d = ST_HALT;
                    default: state_d = ST_HALT;
                endcase
            end
            ST_EXEC: begin
                // Overflow stays sticky until a JNO consumes it
                if (mn_last_s) begin
                    ovf_flag_d = ovf_flag_q | ovf;
                    state_d    = ST_ADV;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_ADV: begin
                pc_d      = pc_q + PC_W'(1);
                pc_wrap_d = &pc_q;
                state_d   = cont_s ? ST_FETCH : ST_IDLE;
            end
            ST_JUMP: begin
                if (!ovf_flag_q) begin
                    pc_d = tgt_q;
                end else begin
                    pc_d      = pc_q + PC_W'(1);
                    pc_wrap_d = &pc_q;
                end
                ovf_flag_d = 1'b0;
                state_d    = cont_s ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath registers and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= {PC_W{1'b0}};
            instr_q     <= 2'b00;
            tgt_q       <= {PC_W{1'b0}};
            ovf_flag_q  <= 1'b0;
            pc_wrap_q   <= 1'b0;
            fetch_req_q <= 1'b0;
            halted_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            tgt_q       <= tgt_d;
            ovf_flag_q  <= ovf_flag_d;
            pc_wrap_q   <= pc_wrap_d;
            fetch_req_q <= (state_d == ST_FETCH);
            halted_q    <= (state_d == ST_HALT);
            busy_q      <= is_active(state_d);
        end
    end

    assign fetch_req = fetch_req_q;
    assign pc        = pc_q;
    assign mn        = mn_s;
    assign pc_wrap   = pc_wrap_q;
    assign halted    = halted_q;
    assign busy      = busy_q;

endmodule
